// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte handshake between a requester and the PS/2 host transmitter
//
// Purpose: groups the valid/ready request that carries one command byte
// to the PS/2 host transmitter.
// Signals:
//   tx_data   8  command byte, sampled on accept
//   tx_valid  1  request from the master
//   tx_ready  1  transmitter idle and able to accept
// Modports: master drives data/valid, slave (the transmitter) drives ready.

interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command byte transmitter
//
// Purpose: sends one command byte to a PS/2 device over the shared open-drain
// ps2clk/ps2dat lines using active-high pull-low enables, and tells the
// neighbouring scancode receiver to ignore the lines while a frame is sent.
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   tx_if         slave side of the command handshake (tx_data/tx_valid/tx_ready)
//   i_ps2clk_in   PS/2 clock pin level (asynchronous)
//   i_ps2dat_in   PS/2 data pin level (asynchronous)
//   o_ps2clk_oe   1 = pull ps2clk low
//   o_ps2dat_oe   1 = pull ps2dat low
//   o_rx_inhibit  1 while a frame is in progress
//   o_done        one-cycle pulse when a frame finishes; o_ack_err valid with it
//   o_ack_err     1 = device did not acknowledge the last frame
//   o_timeout     one-cycle pulse when a frame is aborted by timeout

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic          clk,
  input  logic          rst_n,
  ps2_host_tx_if.slave  tx_if,
  input  logic          i_ps2clk_in,
  input  logic          i_ps2dat_in,
  output logic          o_ps2clk_oe,
  output logic          o_ps2dat_oe,
  output logic          o_rx_inhibit,
  output logic          o_done,
  output logic          o_ack_err,
  output logic          o_timeout
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_INHIBIT  = 2'd1,
    S_REQ      = 2'd2,
    S_WAITIDLE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_bitcnt;
  logic [3:0]       w_bitcnt_nxt;
  logic [9:0]       r_frame;
  logic [9:0]       w_frame_nxt;
  logic             r_clk_oe;
  logic             w_clk_oe_nxt;
  logic             r_dat_oe;
  logic             w_dat_oe_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_ack_err;
  logic             w_ack_err_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;

  // Pin synchronisers; reset to 1 (idle line level) so reset release never looks like a fall.
  logic r_clk_s1;
  logic r_clk_s2;
  logic r_clk_prev;
  logic r_dat_s1;
  logic r_dat_s2;
  logic w_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= i_ps2clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= i_ps2dat_in;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bitcnt  <= '0;
      r_frame   <= '0;
      r_clk_oe  <= 1'b0;
      r_dat_oe  <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_frame   <= w_frame_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_dat_oe  <= w_dat_oe_nxt;
      r_done    <= w_done_nxt;
      r_ack_err <= w_ack_err_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bitcnt_nxt  = r_bitcnt;
    w_frame_nxt   = r_frame;
    w_clk_oe_nxt  = r_clk_oe;
    w_dat_oe_nxt  = r_dat_oe;
    w_done_nxt    = 1'b0;
    w_ack_err_nxt = r_ack_err;
    w_timeout_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_clk_oe_nxt = 1'b0;
        w_dat_oe_nxt = 1'b0;
        if (tx_if.tx_valid) begin
          // Frame bits in send order from bit 0: data LSB first, odd parity, stop.
          w_frame_nxt  = {1'b1, ~^tx_if.tx_data, tx_if.tx_data};
          w_bitcnt_nxt = '0;
          w_cnt_nxt    = '0;
          w_clk_oe_nxt = 1'b1;
          w_state_nxt  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        // Data goes low one cycle before the clock is released so the device
        // sees the request-to-send condition as soon as the clock rises.
        if (r_cnt == INH_PRE) begin
          w_dat_oe_nxt = 1'b1;
        end
        if (r_cnt == INH_LAST) begin
          w_clk_oe_nxt = 1'b0;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_REQ;
        end
      end

      S_REQ: begin
        if (r_cnt == TO_LAST) begin
          w_clk_oe_nxt  = 1'b0;
          w_dat_oe_nxt  = 1'b0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (w_fall) begin
            w_bitcnt_nxt = (r_bitcnt == 4'd11) ? r_bitcnt : r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd10) begin
              // 11th fall: the device drives the ACK bit.
              w_ack_err_nxt = r_dat_s2;
              w_dat_oe_nxt  = 1'b0;
              w_state_nxt   = S_WAITIDLE;
            end else begin
              w_dat_oe_nxt = ~r_frame[0];
              w_frame_nxt  = {1'b0, r_frame[9:1]};
            end
          end
        end
      end

      S_WAITIDLE: begin
        w_clk_oe_nxt = 1'b0;
        w_dat_oe_nxt = 1'b0;
        if (r_cnt == TO_LAST) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (r_clk_s2 && r_dat_s2) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_clk_oe_nxt = 1'b0;
        w_dat_oe_nxt = 1'b0;
        w_state_nxt  = S_IDLE;
      end
    endcase
  end

  assign tx_if.tx_ready = (r_state == S_IDLE);
  assign o_rx_inhibit   = (r_state != S_IDLE);
  assign o_ps2clk_oe    = r_clk_oe;
  assign o_ps2dat_oe    = r_dat_oe;
  assign o_done         = r_done;
  assign o_ack_err      = r_ack_err;
  assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for the PS/2 host transmitter

module tb_ps2_host_tx;

  localparam int INH = 8;
  localparam int TO  = 2000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if tx_if ();

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic w_ps2clk;
  logic w_ps2dat;
  logic o_ps2clk_oe;
  logic o_ps2dat_oe;
  logic o_rx_inhibit;
  logic o_done;
  logic o_ack_err;
  logic o_timeout;

  assign w_ps2clk = ~(o_ps2clk_oe | dev_clk_low);
  assign w_ps2dat = ~(o_ps2dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_if        (tx_if),
    .i_ps2clk_in  (w_ps2clk),
    .i_ps2dat_in  (w_ps2dat),
    .o_ps2clk_oe  (o_ps2clk_oe),
    .o_ps2dat_oe  (o_ps2dat_oe),
    .o_rx_inhibit (o_rx_inhibit),
    .o_done       (o_done),
    .o_ack_err    (o_ack_err),
    .o_timeout    (o_timeout)
  );

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int to_cnt   = 0;
  int acc_cnt  = 0;
  int inh_viol = 0;
  bit in_frame = 1'b0;

  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (o_timeout) to_cnt++;
    if (in_frame && !o_rx_inhibit && !o_done) inh_viol++;
  end

  always @(posedge clk) begin
    if (rst_n && tx_if.tx_valid && tx_if.tx_ready) acc_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         exp_par;
    bit         exp_ack_err;
  } vec_t;

  vec_t vecs[6];

  task automatic dev_pulse(output logic b);
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    b = w_ps2dat;
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] data, input bit ack, input bit raise_valid,
                           input bit hold_valid, output logic [9:0] bits, output int inh_len,
                           output logic start_bit, output bit got_done, output logic ack_seen);
    int   n;
    logic b;
    if (raise_valid) begin
      tx_if.tx_data  = data;
      tx_if.tx_valid = 1'b1;
      @(negedge clk);
    end
    if (!hold_valid) tx_if.tx_valid = 1'b0;
    n = 0;
    while (!o_ps2clk_oe && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_frame = 1'b1;
    inh_len  = 0;
    while (o_ps2clk_oe && inh_len < 100) begin
      @(negedge clk);
      inh_len++;
    end
    start_bit = w_ps2dat;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      dev_pulse(b);
      bits[k] = b;
    end
    if (ack) dev_dat_low = 1'b1;
    dev_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    got_done = 1'b0;
    n = 0;
    while (!got_done && n < 100) begin
      @(negedge clk);
      n++;
      if (o_done) got_done = 1'b1;
    end
    ack_seen = o_ack_err;
    in_frame = 1'b0;
  endtask

  logic [9:0] bits;
  int         inh_len;
  logic       start_bit;
  bit         got_done;
  logic       ack_seen;
  int         d0;
  int         t0;
  int         a0;
  int         n;
  logic       b;

  initial begin
    vecs[0] = '{data: 8'hED, ack: 1'b1, exp_par: 1'b1, exp_ack_err: 1'b0};
    vecs[1] = '{data: 8'h01, ack: 1'b1, exp_par: 1'b0, exp_ack_err: 1'b0};
    vecs[2] = '{data: 8'h00, ack: 1'b1, exp_par: 1'b1, exp_ack_err: 1'b0};
    vecs[3] = '{data: 8'hFF, ack: 1'b1, exp_par: 1'b1, exp_ack_err: 1'b0};
    vecs[4] = '{data: 8'h80, ack: 1'b1, exp_par: 1'b0, exp_ack_err: 1'b0};
    vecs[5] = '{data: 8'hA5, ack: 1'b0, exp_par: 1'b1, exp_ack_err: 1'b1};

    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx_ready", tx_if.tx_ready, 1);
    chk("reset clk_oe", o_ps2clk_oe, 0);
    chk("reset dat_oe", o_ps2dat_oe, 0);
    chk("reset done", o_done, 0);
    chk("reset ack_err", o_ack_err, 0);
    chk("reset timeout", o_timeout, 0);
    chk("reset rx_inhibit", o_rx_inhibit, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clock edges while idle must not start or disturb anything.
    for (int k = 0; k < 3; k++) begin
      dev_clk_low = 1'b1;
      repeat (4) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk("idle falls tx_ready", tx_if.tx_ready, 1);
    chk("idle falls clk_oe", o_ps2clk_oe, 0);
    chk("idle falls dat_oe", o_ps2dat_oe, 0);

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      run_frame(vecs[i].data, vecs[i].ack, 1'b1, 1'b0, bits, inh_len, start_bit, got_done, ack_seen);
      chk($sformatf("v%0d inhibit len", i), inh_len, INH);
      chk($sformatf("v%0d start bit", i), start_bit, 0);
      chk($sformatf("v%0d data bits", i), bits[7:0], vecs[i].data);
      chk($sformatf("v%0d parity", i), bits[8], vecs[i].exp_par);
      chk($sformatf("v%0d stop", i), bits[9], 1);
      chk($sformatf("v%0d done seen", i), got_done, 1);
      chk($sformatf("v%0d ack_err", i), ack_seen, vecs[i].exp_ack_err);
      @(negedge clk);
      chk($sformatf("v%0d done width", i), o_done, 0);
      chk($sformatf("v%0d done count", i), done_cnt - d0, 1);
      chk($sformatf("v%0d tx_ready after", i), tx_if.tx_ready, 1);
      chk($sformatf("v%0d clk_oe released", i), o_ps2clk_oe, 0);
      chk($sformatf("v%0d dat_oe released", i), o_ps2dat_oe, 0);
      chk($sformatf("v%0d ack_err held", i), o_ack_err, vecs[i].exp_ack_err);
      repeat (5) @(negedge clk);
    end

    // Device never clocks: timeout 2000 cycles after the request state is entered.
    d0 = done_cnt;
    t0 = to_cnt;
    tx_if.tx_data  = 8'h3C;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    n = 0;
    while (!o_ps2clk_oe && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (o_ps2clk_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!o_timeout && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout latency", n, TO);
    chk("timeout clk_oe", o_ps2clk_oe, 0);
    chk("timeout dat_oe", o_ps2dat_oe, 0);
    chk("timeout tx_ready", tx_if.tx_ready, 1);
    chk("timeout ack_err unchanged", o_ack_err, 1);
    @(negedge clk);
    chk("timeout width", o_timeout, 0);
    chk("timeout count", to_cnt - t0, 1);
    chk("timeout no done", done_cnt - d0, 0);
    repeat (5) @(negedge clk);

    // Reset in the middle of a frame, just after the 5th fall.
    d0 = done_cnt;
    t0 = to_cnt;
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    n = 0;
    while (!o_ps2clk_oe && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (o_ps2clk_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    for (int k = 0; k < 4; k++) dev_pulse(b);
    dev_clk_low = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid-frame dat_oe before reset", o_ps2dat_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset clk_oe", o_ps2clk_oe, 0);
    chk("async reset dat_oe", o_ps2dat_oe, 0);
    chk("async reset tx_ready", tx_if.tx_ready, 1);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset no done", done_cnt - d0, 0);
    chk("reset no timeout", to_cnt - t0, 0);
    run_frame(8'hFF, 1'b1, 1'b1, 1'b0, bits, inh_len, start_bit, got_done, ack_seen);
    chk("post-reset inhibit", inh_len, INH);
    chk("post-reset start", start_bit, 0);
    chk("post-reset frame", bits, 10'h3FF);
    chk("post-reset done", got_done, 1);
    chk("post-reset ack_err", ack_seen, 0);
    repeat (5) @(negedge clk);

    // tx_valid held high: one frame, the next accepted only once done fires.
    a0 = acc_cnt;
    inh_viol = 0;
    run_frame(8'h5A, 1'b1, 1'b1, 1'b1, bits, inh_len, start_bit, got_done, ack_seen);
    chk("held valid single accept", acc_cnt - a0, 1);
    chk("held valid done", got_done, 1);
    chk("held valid frame", bits, {2'b11, 8'h5A});
    @(negedge clk);
    chk("held valid re-accept after done", acc_cnt - a0, 2);
    chk("held valid next inhibit started", o_ps2clk_oe, 1);
    run_frame(8'h5A, 1'b1, 1'b0, 1'b0, bits, inh_len, start_bit, got_done, ack_seen);
    chk("second frame inhibit", inh_len, INH);
    chk("second frame bits", bits, {2'b11, 8'h5A});
    chk("second frame done", got_done, 1);
    @(negedge clk);
    chk("no extra accept", acc_cnt - a0, 2);
    chk("rx_inhibit through frames", inh_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
